imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 14 +
 rtl/imem_loader_byte_assembler.sv | 40 ++++
 rtl/imem_loader.sv | 140 ++++++++++++++
 tb/tb_imem_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader shared constants: FSM encoding, HALT word, bytes per word.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (see imem_loader.sv).
package imem_loader_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RECEIVE = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Big-endian byte-to-word shift register with a byte counter.
// First accepted byte ends up in the top byte of the word.
module imem_loader_byte_assembler
  import imem_loader_pkg::*;
#(
  parameter int NB_BYTE = 8,
  parameter int WORD_W  = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_accept,
  input  logic [NB_BYTE-1:0] i_byte,
  output logic [WORD_W-1:0]  o_word,
  output logic               o_word_complete
);

  logic [WORD_W-1:0] shift_q;
  logic [1:0]        cnt_q;

  assign o_word = shift_q;

  assign o_word_complete =
    i_accept && (cnt_q == 2'(BYTES_PER_WORD - 1));

  // shift each accepted byte in from the bottom; clear drops partial word
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (i_clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (i_accept) begin
      shift_q <= {shift_q[WORD_W-NB_BYTE-1:0], i_byte};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program-load controller: bytes -> words -> imem, then read port to IF.
// Define IMEM_LOADER_CHECKSUM_EN to enable the running byte checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int              MEMORY_WIDTH = 32,
  parameter int              MEMORY_DEPTH = 64,
  parameter int              NB_ADDR      = 32,
  parameter int              NB_BYTE      = 8,
  parameter logic [31:0]     HALT_WORD    = HALT_WORD_DEF
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_byte_valid,
  input  logic [NB_BYTE-1:0]      i_byte,
  output logic                    o_byte_ready,
  input  logic                    i_fetch_enable,
  input  logic [NB_ADDR-1:0]      i_fetch_addr,
  output logic                    o_imem_write_enable,
  output logic [NB_ADDR-1:0]      o_imem_write_addr,
  output logic [MEMORY_WIDTH-1:0] o_imem_write_data,
  output logic                    o_imem_read_enable,
  output logic [NB_ADDR-1:0]      o_imem_read_addr,
  output logic                    o_loading,
  output logic                    o_load_done,
  output logic [NB_ADDR-1:0]      o_word_count,
  output logic                    o_overflow_error,
  output logic [NB_BYTE-1:0]      o_checksum
);

  logic [1:0]              state_q, state_d;
  logic [NB_ADDR-1:0]      word_count_q, word_count_d;
  logic                    overflow_q, overflow_d;
  logic                    start_load;
  logic                    accept;
  logic                    word_complete;
  logic [MEMORY_WIDTH-1:0] word;
  logic                    in_write;
  logic                    in_done;

  assign in_write = (state_q == ST_WRITE);
  assign in_done  = (state_q == ST_DONE);

  assign start_load = i_start &&
    ((state_q == ST_IDLE) || in_done);

  assign o_byte_ready = (state_q == ST_RECEIVE);
  assign accept       = i_byte_valid && o_byte_ready;

  imem_loader_byte_assembler #(
    .NB_BYTE (NB_BYTE),
    .WORD_W  (MEMORY_WIDTH)
  ) u_byte_assembler (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_clear         (start_load),
    .i_accept        (accept),
    .i_byte          (i_byte),
    .o_word          (word),
    .o_word_complete (word_complete)
  );

  // load sequencing and word bookkeeping
  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    overflow_d   = overflow_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_load) begin
          state_d      = ST_RECEIVE;
          word_count_d = '0;
          overflow_d   = 1'b0;
        end
      end
      ST_RECEIVE: begin
        if (word_complete) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        word_count_d = word_count_q + NB_ADDR'(1);
        if (word == MEMORY_WIDTH'(HALT_WORD)) begin
          state_d = ST_DONE;
        end else if (word_count_q ==
                     NB_ADDR'(MEMORY_DEPTH - 1)) begin
          state_d    = ST_DONE;
          overflow_d = 1'b1;
        end else begin
          state_d = ST_RECEIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and counters
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign o_imem_write_enable = in_write;
  assign o_imem_write_addr   = in_write ? word_count_q : '0;
  assign o_imem_write_data   = in_write ? word : '0;

  assign o_imem_read_enable = in_done && i_fetch_enable;
  assign o_imem_read_addr   = in_done ? i_fetch_addr : '0;

  assign o_loading        = o_byte_ready || in_write;
  assign o_load_done      = in_done;
  assign o_word_count     = word_count_q;
  assign o_overflow_error = overflow_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [NB_BYTE-1:0] checksum_q;

  // modulo-2^NB_BYTE sum of accepted bytes, restarted with each load
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      checksum_q <= '0;
    end else if (start_load) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= checksum_q + i_byte;
    end
  end

  assign o_checksum = checksum_q;
`else
  assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued by stimulus,
// popped and compared by a monitor on each write strobe.
module tb_imem_loader;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic        i_byte_valid;
  logic [7:0]  i_byte;
  logic        o_byte_ready;
  logic        i_fetch_enable;
  logic [31:0] i_fetch_addr;
  logic        o_imem_write_enable;
  logic [31:0] o_imem_write_addr;
  logic [31:0] o_imem_write_data;
  logic        o_imem_read_enable;
  logic [31:0] o_imem_read_addr;
  logic        o_loading;
  logic        o_load_done;
  logic [31:0] o_word_count;
  logic        o_overflow_error;
  logic [7:0]  o_checksum;

  int n_pass = 0;
  int n_total = 0;
  logic [63:0] exp_q[$];

  imem_loader dut (
    .i_clock             (i_clock),
    .i_reset             (i_reset),
    .i_start             (i_start),
    .i_byte_valid        (i_byte_valid),
    .i_byte              (i_byte),
    .o_byte_ready        (o_byte_ready),
    .i_fetch_enable      (i_fetch_enable),
    .i_fetch_addr        (i_fetch_addr),
    .o_imem_write_enable (o_imem_write_enable),
    .o_imem_write_addr   (o_imem_write_addr),
    .o_imem_write_data   (o_imem_write_data),
    .o_imem_read_enable  (o_imem_read_enable),
    .o_imem_read_addr    (o_imem_read_addr),
    .o_loading           (o_loading),
    .o_load_done         (o_load_done),
    .o_word_count        (o_word_count),
    .o_overflow_error    (o_overflow_error),
    .o_checksum          (o_checksum)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // monitor: every write strobe must match the head of the queue
  always @(negedge i_clock) begin
    if (o_imem_write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", o_imem_write_addr, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("write_addr", o_imem_write_addr, e[63:32]);
        check("write_data", o_imem_write_data, e[31:0]);
      end
    end
  end

  task automatic pulse_start();
    @(negedge i_clock);
    i_start = 1'b1;
    @(negedge i_clock);
    i_start = 1'b0;
  endtask

  // returns #1 after the accepting edge
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge i_clock);
    i_byte_valid = 1'b1;
    i_byte = b;
    while (o_byte_ready !== 1'b1 && n < 20) begin
      @(negedge i_clock);
      n++;
    end
    if (n == 20) check("byte_ready_timeout", 32'd0, 32'd1);
    @(posedge i_clock);
    #1;
    i_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] addr,
                           input logic [31:0] w);
    exp_q.push_back({addr, w});
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(o_byte_ready), 0);
    check({tag, "_we"}, 32'(o_imem_write_enable), 0);
    check({tag, "_waddr"}, o_imem_write_addr, 0);
    check({tag, "_wdata"}, o_imem_write_data, 0);
    check({tag, "_re"}, 32'(o_imem_read_enable), 0);
    check({tag, "_raddr"}, o_imem_read_addr, 0);
    check({tag, "_loading"}, 32'(o_loading), 0);
    check({tag, "_done"}, 32'(o_load_done), 0);
    check({tag, "_count"}, o_word_count, 0);
    check({tag, "_ovf"}, 32'(o_overflow_error), 0);
    check({tag, "_csum"}, 32'(o_checksum), 0);
  endtask

  logic [7:0] seq [12] = '{8'h11, 8'h22, 8'h33, 8'h44,
                           8'h55, 8'h66, 8'h77, 8'h88,
                           8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] exp_csum;

  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    i_byte_valid = 1'b0;
    i_byte = '0;
    i_fetch_enable = 1'b1;
    i_fetch_addr = 32'd1;
    repeat (3) @(negedge i_clock);
    check_idle_outputs("reset");
    i_reset = 1'b0;
    @(negedge i_clock);
    check("preload_re", 32'(o_imem_read_enable), 0);
    check("preload_raddr", o_imem_read_addr, 0);
    i_fetch_enable = 1'b0;

    // basic load with HALT
    pulse_start();
    check("loading_after_start", 32'(o_loading), 1);
    send_word(32'd0, 32'h0000_000A);
    send_word(32'd1, 32'h0000_0014);
    send_word(32'd2, 32'hFFFF_FFFF);
    check("done_not_yet", 32'(o_load_done), 0);
    @(posedge i_clock); #1;
    check("basic_done", 32'(o_load_done), 1);
    check("basic_count", o_word_count, 3);
    check("basic_ovf", 32'(o_overflow_error), 0);
    check("basic_loading", 32'(o_loading), 0);
    i_fetch_enable = 1'b1;
    i_fetch_addr = 32'd1;
    #1;
    check("fetch_re", 32'(o_imem_read_enable), 1);
    check("fetch_raddr", o_imem_read_addr, 1);
    i_fetch_addr = 32'd2;
    i_fetch_enable = 1'b0;
    #1;
    check("fetch_re_off", 32'(o_imem_read_enable), 0);
    check("fetch_raddr2", o_imem_read_addr, 2);

    // overflow: 64 non-HALT words
    pulse_start();
    check("ovf_count_cleared", o_word_count, 0);
    for (int i = 0; i < 64; i++) send_word(32'(i), 32'(i));
    @(posedge i_clock); #1;
    check("ovf_done", 32'(o_load_done), 1);
    check("ovf_flag", 32'(o_overflow_error), 1);
    check("ovf_count", o_word_count, 64);
    pulse_start();
    check("ovf_cleared", 32'(o_overflow_error), 0);

    // continuous valid: byte during WRITE is held off
    begin
      int idx, cyc;
      logic acc;
      idx = 0;
      cyc = 0;
      exp_q.push_back({32'd0, 32'h1122_3344});
      exp_q.push_back({32'd1, 32'h5566_7788});
      exp_q.push_back({32'd2, 32'hFFFF_FFFF});
      @(negedge i_clock);
      i_byte_valid = 1'b1;
      while (idx < 12 && cyc < 60) begin
        i_byte = seq[idx];
        #1;
        if (o_imem_write_enable)
          check("ready_low_in_write", 32'(o_byte_ready), 0);
        acc = o_byte_ready;
        @(negedge i_clock);
        if (acc) idx++;
        cyc++;
      end
      i_byte_valid = 1'b0;
      if (idx < 12) check("stream_timeout", 32'(idx), 12);
      @(posedge i_clock); #1;
      check("stream_done", 32'(o_load_done), 1);
      check("stream_count", o_word_count, 3);
    end

    // checksum
    pulse_start();
    send_word(32'd0, 32'h0102_0304);
    send_word(32'd1, 32'hFFFF_FFFF);
    @(posedge i_clock); #1;
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_csum = 8'h06;
`else
    exp_csum = 8'h00;
`endif
    check("csum_done", 32'(o_load_done), 1);
    check("checksum", 32'(o_checksum), 32'(exp_csum));

    // reset mid-load, then reload from address 0
    pulse_start();
    send_word(32'd0, 32'hAABB_CCDD);
    send_byte(8'h12);
    send_byte(8'h34);
    @(negedge i_clock);
    i_reset = 1'b1;
    #1;
    check_idle_outputs("midreset");
    check("queue_empty_at_reset", 32'(exp_q.size()), 0);
    @(negedge i_clock);
    i_reset = 1'b0;
    pulse_start();
    send_word(32'd0, 32'hDEAD_BEEF);
    send_word(32'd1, 32'hFFFF_FFFF);
    @(posedge i_clock); #1;
    check("reload_done", 32'(o_load_done), 1);
    check("reload_count", o_word_count, 2);
    repeat (2) @(negedge i_clock);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
